// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_pkg
// Description : Shared constants for the bus select pipeline: the default
//               upper-byte-immediate opcode, the opcode field position inside
//               the instruction word, and the immediate field widths.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

  // Instruction word width carried on the immediate channel
  localparam int INSTR_W = 16;

  // Opcode field position inside the instruction word
  localparam int OP_MSB = 15;
  localparam int OP_LSB = 13;
  localparam int OP_W   = OP_MSB - OP_LSB + 1;

  // Default opcode selecting the upper-byte immediate form
  localparam logic [OP_W-1:0] MVT_OP = 3'b001;

  // Immediate field widths: 8-bit upper-byte immediate, 9-bit signed immediate
  localparam int IMM_HI_W = 8;
  localparam int IMM_SX_W = 9;

  // Extract the opcode field from an instruction word
  function automatic logic [OP_W-1:0] get_opcode(input logic [INSTR_W-1:0] instr);
    return instr[OP_MSB:OP_LSB];
  endfunction

endpackage : bus_pkg
`default_nettype wire

// File: rtl/imm_format.sv
`default_nettype none
// ============================================================================
// Module      : imm_format
// Description : Combinational immediate formatter. The upper-byte opcode
//               places instr[7:0] in the top byte of the result with zeros
//               below; every other opcode sign-extends instr[8:0].
// Revision    : 1.0 - initial release
// ============================================================================
module imm_format
  import bus_pkg::*;
#(
  parameter int              WIDTH  = 16,
  parameter logic [OP_W-1:0] MVT_OP = bus_pkg::MVT_OP
) (
  input  logic [INSTR_W-1:0] instr_i,
  output logic [WIDTH-1:0]   imm_o
);

  logic [OP_W-1:0] w_op;
  logic            w_is_mvt;

  assign w_op     = get_opcode(instr_i);
  assign w_is_mvt = (w_op == MVT_OP);

  // Select between upper-byte placement and 9-bit sign extension
  always_comb begin
    imm_o = '0;
    if (w_is_mvt) begin
      imm_o = {instr_i[IMM_HI_W-1:0], {(WIDTH-IMM_HI_W){1'b0}}};
    end else begin
      imm_o = {{(WIDTH-IMM_SX_W){instr_i[IMM_SX_W-1]}}, instr_i[IMM_SX_W-1:0]};
    end
  end

endmodule : imm_format
`default_nettype wire

// File: rtl/bus_sel_pipe.sv
`default_nettype none
// ============================================================================
// Module      : bus_sel_pipe
// Description : Selects one of NUM_IN data channels, optionally formats the
//               instruction channel as an immediate, and queues the result in
//               a two-entry output/skid register pair with valid/ready
//               handshakes on both sides. in_ready is fully registered so the
//               consumer's out_ready never reaches the producer combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_sel_pipe
  import bus_pkg::*;
#(
  parameter int              WIDTH   = 16,
  parameter int              NUM_IN  = 11,
  parameter int              IMM_IDX = 8,
  parameter logic [OP_W-1:0] MVT_OP  = bus_pkg::MVT_OP
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [3:0]              sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  generate
    if (WIDTH < 16) begin : g_bad_width
      $error("bus_sel_pipe: WIDTH must be at least 16");
    end
    if (NUM_IN < 2 || NUM_IN > 16) begin : g_bad_num_in
      $error("bus_sel_pipe: NUM_IN must be in the range 2..16");
    end
    if (IMM_IDX < 0 || IMM_IDX >= NUM_IN) begin : g_bad_imm_idx
      $error("bus_sel_pipe: IMM_IDX must address an existing channel");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Channel selection and formatting
  // --------------------------------------------------------------------------
  logic               w_sel_ok;
  logic               w_sel_imm;
  logic [WIDTH-1:0]   w_chan;
  logic [INSTR_W-1:0] w_instr;
  logic [WIDTH-1:0]   w_imm;
  logic [WIDTH-1:0]   w_fmt;

  // sel is 4 bits wide, so widen it before comparing with NUM_IN (up to 16)
  assign w_sel_ok  = ({1'b0, sel} < 5'(NUM_IN));
  assign w_sel_imm = (sel == 4'(IMM_IDX));

  // The instruction lives in the low 16 bits of the immediate channel
  assign w_instr = in_data[IMM_IDX*WIDTH +: INSTR_W];

  // Plain channel multiplexer; out-of-range selects fall through to zero
  always_comb begin
    w_chan = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == 4'(k)) begin
        w_chan = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  imm_format #(
    .WIDTH  (WIDTH),
    .MVT_OP (MVT_OP)
  ) u_imm_format (
    .instr_i (w_instr),
    .imm_o   (w_imm)
  );

  // Final beat value: zero for illegal selects, immediate for the instruction
  // channel, raw channel data otherwise
  always_comb begin
    w_fmt = '0;
    if (!w_sel_ok) begin
      w_fmt = '0;
    end else if (w_sel_imm) begin
      w_fmt = w_imm;
    end else begin
      w_fmt = w_chan;
    end
  end

  // --------------------------------------------------------------------------
  // Output register (OR) and skid register (SR)
  // --------------------------------------------------------------------------
  logic             or_valid_q, or_valid_d;
  logic [WIDTH-1:0] or_data_q,  or_data_d;
  logic             sr_valid_q, sr_valid_d;
  logic [WIDTH-1:0] sr_data_q,  sr_data_d;
  logic             in_ready_q;
  logic             sel_err_q;

  logic w_acc;
  logic w_xfer;

  assign w_acc  = in_valid && in_ready_q;
  assign w_xfer = or_valid_q && out_ready;

  // Next-state for the two-entry queue. An accept never coincides with a
  // full skid register because in_ready mirrors the skid register's emptiness.
  always_comb begin
    or_valid_d = or_valid_q;
    or_data_d  = or_data_q;
    sr_valid_d = sr_valid_q;
    sr_data_d  = sr_data_q;
    if (w_xfer) begin
      if (sr_valid_q) begin
        // Oldest waiting beat advances into the output register
        or_data_d  = sr_data_q;
        sr_valid_d = 1'b0;
      end else if (w_acc) begin
        // Drain and refill in the same cycle: out_valid stays high
        or_data_d  = w_fmt;
      end else begin
        or_valid_d = 1'b0;
      end
    end else if (!or_valid_q) begin
      if (w_acc) begin
        or_valid_d = 1'b1;
        or_data_d  = w_fmt;
      end
    end else if (w_acc) begin
      // Output is stalled, so the new beat parks in the skid register
      sr_valid_d = 1'b1;
      sr_data_d  = w_fmt;
    end
  end

  // Register update; in_ready is the registered complement of the next SR state
  always_ff @(posedge clk) begin
    if (reset) begin
      or_valid_q <= 1'b0;
      or_data_q  <= '0;
      sr_valid_q <= 1'b0;
      sr_data_q  <= '0;
      in_ready_q <= 1'b0;
      sel_err_q  <= 1'b0;
    end else begin
      or_valid_q <= or_valid_d;
      or_data_q  <= or_data_d;
      sr_valid_q <= sr_valid_d;
      sr_data_q  <= sr_data_d;
      in_ready_q <= !sr_valid_d;
      sel_err_q  <= w_acc && !w_sel_ok;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = or_valid_q;
  assign out_data  = or_data_q;
  assign sel_err   = sel_err_q;

endmodule : bus_sel_pipe
`default_nettype wire

// File: tb/tb_bus_sel_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_sel_pipe
// Description : Self-checking bench for bus_sel_pipe. A queue-based reference
//               model tracks the beats held by the block; directed scenarios
//               and a randomized run compare the DUT against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_sel_pipe;

  localparam int WIDTH   = 16;
  localparam int NUM_IN  = 11;
  localparam int IMM_IDX = 8;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [3:0]              sel;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    sel_err;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [WIDTH-1:0] q[$];
  logic             m_rdy = 1'b0;
  logic             m_err = 1'b0;

  bus_sel_pipe #(
    .WIDTH   (WIDTH),
    .NUM_IN  (NUM_IN),
    .IMM_IDX (IMM_IDX),
    .MVT_OP  (3'b001)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel_err   (sel_err)
  );

  always #5 clk = ~clk;

  // Expected beat value computed directly from the formatting rules
  function automatic logic [WIDTH-1:0] ref_fmt(input int s, input logic [NUM_IN*WIDTH-1:0] d);
    logic [WIDTH-1:0] w;
    int v;
    if (s >= NUM_IN) return '0;
    w = d[s*WIDTH +: WIDTH];
    if (s != IMM_IDX) return w;
    if (w[15:13] == 3'b001) return WIDTH'(int'(w[7:0]) * 256);
    v = int'(w[8:0]);
    if (v > 255) v = v - 512;
    return WIDTH'(v);
  endfunction

  // Apply one cycle of stimulus and advance the reference model past the edge
  task automatic cycle(input logic rst, input logic v, input logic [3:0] s, input logic ordy);
    logic acc, xfer;
    logic [WIDTH-1:0] f;
    reset     = rst;
    in_valid  = v;
    sel       = s;
    out_ready = ordy;
    acc  = !rst && v && m_rdy;
    xfer = !rst && ordy && (q.size() != 0);
    f    = ref_fmt(int'(s), in_data);
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      m_rdy = 1'b0;
      m_err = 1'b0;
    end else begin
      if (xfer) void'(q.pop_front());
      if (acc) q.push_back(f);
      m_err = acc && (int'(s) >= NUM_IN);
      m_rdy = (q.size() < 2);
    end
  endtask

  task automatic set_ch(input int k, input logic [WIDTH-1:0] val);
    in_data[k*WIDTH +: WIDTH] = val;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'(i), 4'(i), 1'b0);
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || sel_err !== 1'b0 || out_data !== '0) begin
      n_err++;
      $display("FAIL reset_state: valid=%b rdy=%b err=%b data=%h, want 0 0 0 0000",
               out_valid, in_ready, sel_err, out_data);
    end
    cycle(1'b0, 1'b0, 4'd0, 1'b0);
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: rdy=%b valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_passthru();
    set_ch(3, 16'hBEEF);
    cycle(1'b0, 1'b1, 4'd3, 1'b1);
    set_ch(3, 16'h0000);
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 16'hBEEF) begin
      n_err++;
      $display("FAIL passthru: valid=%b data=%h, want 1 beef", out_valid, out_data);
    end
    cycle(1'b0, 1'b0, 4'd0, 1'b1);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL passthru_drain: valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_imm();
    logic [WIDTH-1:0] instr [2];
    logic [WIDTH-1:0] want  [2];
    instr[0] = 16'h2A5C; want[0] = 16'h5C00;
    instr[1] = 16'h0180; want[1] = 16'hFF80;
    for (int i = 0; i < 2; i++) begin
      set_ch(IMM_IDX, instr[i]);
      cycle(1'b0, 1'b1, 4'(IMM_IDX), 1'b1);
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== want[i]) begin
        n_err++;
        $display("FAIL imm_%0d: valid=%b data=%h, want 1 %h", i, out_valid, out_data, want[i]);
      end
    end
    cycle(1'b0, 1'b0, 4'd0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] want [3];
    want[0] = 16'hA0A0; want[1] = 16'hB1B1; want[2] = 16'hC2C2;
    for (int i = 0; i < 3; i++) set_ch(i, want[i]);
    cycle(1'b0, 1'b1, 4'd0, 1'b0);
    cycle(1'b0, 1'b1, 4'd1, 1'b0);
    n_vec++;
    if (in_ready !== 1'b0 || out_data !== want[0]) begin
      n_err++;
      $display("FAIL b2b_full: rdy=%b data=%h, want 0 %h", in_ready, out_data, want[0]);
    end
    cycle(1'b0, 1'b1, 4'd2, 1'b0);
    n_vec++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== want[0]) begin
      n_err++;
      $display("FAIL b2b_stall: rdy=%b valid=%b data=%h, want 0 1 %h",
               in_ready, out_valid, out_data, want[0]);
    end
    cycle(1'b0, 1'b1, 4'd2, 1'b1);
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== want[1] || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_second: valid=%b data=%h rdy=%b, want 1 %h 1",
               out_valid, out_data, in_ready, want[1]);
    end
    cycle(1'b0, 1'b1, 4'd2, 1'b1);
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== want[2]) begin
      n_err++;
      $display("FAIL b2b_third: valid=%b data=%h, want 1 %h", out_valid, out_data, want[2]);
    end
    cycle(1'b0, 1'b0, 4'd0, 1'b1);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_empty: valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_sel_err();
    cycle(1'b0, 1'b1, 4'd12, 1'b1);
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== '0 || sel_err !== 1'b1) begin
      n_err++;
      $display("FAIL sel_err_hit: valid=%b data=%h err=%b, want 1 0000 1",
               out_valid, out_data, sel_err);
    end
    cycle(1'b0, 1'b0, 4'd12, 1'b1);
    n_vec++;
    if (sel_err !== 1'b0) begin
      n_err++;
      $display("FAIL sel_err_pulse: err=%b, want 0", sel_err);
    end
  endtask

  task automatic test_reset_full();
    set_ch(4, 16'h1111);
    set_ch(6, 16'h2222);
    cycle(1'b0, 1'b1, 4'd4, 1'b0);
    cycle(1'b0, 1'b1, 4'd6, 1'b0);
    cycle(1'b1, 1'b0, 4'd0, 1'b0);
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_full: valid=%b rdy=%b, want 0 0", out_valid, in_ready);
    end
    cycle(1'b0, 1'b0, 4'd0, 1'b1);
    set_ch(5, 16'h1234);
    cycle(1'b0, 1'b1, 4'd5, 1'b1);
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 16'h1234) begin
      n_err++;
      $display("FAIL reset_full_new: valid=%b data=%h, want 1 1234", out_valid, out_data);
    end
    cycle(1'b0, 1'b0, 4'd0, 1'b1);
  endtask

  task automatic test_random();
    logic exp_ov;
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < NUM_IN; k++) set_ch(k, WIDTH'($urandom));
      // Bias the instruction channel toward the upper-byte opcode
      if ($urandom_range(0, 3) == 0) in_data[IMM_IDX*WIDTH+13 +: 3] = 3'b001;
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7),
            4'($urandom_range(0, 15)), ($urandom_range(0, 9) < 5));
      exp_ov = (q.size() != 0);
      n_vec++;
      if (out_valid !== exp_ov || in_ready !== m_rdy || sel_err !== m_err ||
          (exp_ov && out_data !== q[0])) begin
        n_err++;
        $display("FAIL random_%0d: valid=%b rdy=%b err=%b data=%h, want %b %b %b %h",
                 n, out_valid, in_ready, sel_err, out_data, exp_ov, m_rdy, m_err,
                 exp_ov ? q[0] : out_data);
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_data   = '0;
    sel       = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_passthru();
    test_imm();
    test_back_to_back();
    test_sel_err();
    test_reset_full();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_bus_sel_pipe
`default_nettype wire

// File: doc/bus_sel_pipe.md
BUS_SEL_PIPE -- requirements
Module: bus_sel_pipe

Interface
REQ-001 Parameter WIDTH, default 16: data bus width in bits; the block SHALL reject WIDTH < 16 at elaboration.
REQ-002 Parameter NUM_IN, default 11: number of data channels; legal range 2..16.
REQ-003 Parameter IMM_IDX, default 8: channel index that carries the raw instruction word for immediate formatting.
REQ-004 Parameter MVT_OP, default 3'b001: opcode in instruction bits [15:13] that selects upper-byte immediate mode.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-007 in_data  input  NUM_IN*WIDTH  flattened channels; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-008 sel  input  4  channel select, qualified by in_valid.
REQ-009 in_valid  input  1  request to transfer the selected channel.
REQ-010 in_ready  output  1  block can accept a request this cycle.
REQ-011 out_data  output  WIDTH  registered result.
REQ-012 out_valid  output  1  out_data holds a result.
REQ-013 out_ready  input  1  consumer takes out_data this cycle.
REQ-014 sel_err  output  1  one-cycle pulse: an accepted request had sel >= NUM_IN.

Function
REQ-015 Accept = in_valid && in_ready; output transfer = out_valid && out_ready.
REQ-016 Formatting on accept: sel < NUM_IN and sel != IMM_IDX passes channel sel unchanged.
REQ-017 sel == IMM_IDX with instruction[15:13] == MVT_OP yields {instruction[7:0], (WIDTH-8) zeros}.
REQ-018 sel == IMM_IDX with any other opcode yields instruction[8:0] sign-extended from bit 8 to WIDTH.
REQ-019 sel >= NUM_IN yields all-zero data, still enqueues a beat, and raises sel_err in the cycle after accept.
REQ-020 Storage: one output register (OR) plus one skid register (SR), each with a valid flag; maximum occupancy 2.
REQ-021 Latency: an accepted beat appears on out_data/out_valid exactly one cycle after accept when OR is empty or is transferring that cycle.
REQ-022 An accepted beat while OR is valid and out_ready=0 SHALL be written to SR.
REQ-023 On output transfer with SR valid, SR moves to OR next cycle and SR becomes empty; beat order is strictly FIFO.
REQ-024 in_ready SHALL be a registered signal equal to !SR.valid; no combinational path from out_ready to in_ready.
REQ-025 Simultaneous accept and transfer with SR empty: the new beat replaces OR and out_valid stays 1.
REQ-026 Simultaneous accept and transfer with SR valid is impossible by REQ-024.
REQ-027 out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-028 in_data and sel are sampled only on accept; later changes do not affect stored beats.

Reset
REQ-029 While reset=1: out_valid=0, SR.valid=0, out_data=0, sel_err=0, in_ready=0.
REQ-030 in_ready SHALL be 1 from the first cycle after reset deasserts.
REQ-031 Reset mid-transfer SHALL drop all stored beats without presenting them.

Structure
REQ-032 Shared package (bus_pkg) holds MVT_OP, the opcode field position [15:13], and the immediate field widths (8 and 9).
REQ-033 One sub-module, imm_format, SHALL implement REQ-017/REQ-018 combinationally; bus_sel_pipe instantiates it once.

Verification
REQ-034 Reset, then sel=3, ch3=16'hBEEF, out_ready=1 -> out_data=16'hBEEF, out_valid=1 one cycle after accept.
REQ-035 sel=8, instruction=16'h2A5C (op 001) -> 16'h5C00; instruction=16'h0180 (op 000) -> 16'hFF80.
REQ-036 out_ready=0, three back-to-back beats A,B,C -> A, B accepted; in_ready=0 from the cycle after B's accept; C stalled; out_ready=1 -> outputs A,B,C in order, no loss or duplicate.
REQ-037 NUM_IN=11, sel=12 -> out_data=0, sel_err high exactly one cycle.
REQ-038 Reset asserted with both registers full -> next cycle out_valid=0 and in_ready=0; after release, the first new beat is output unaffected by the dropped beats.
